// File: rtl/mul_div_unit_if.sv
// Handshake and result bundle between the control unit and the multiply/divide engine.
interface mul_div_unit_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic             op;
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic             busy;
   logic             done;
   logic             div_by_zero;
   logic [WIDTH-1:0] z_hi;
   logic [WIDTH-1:0] z_lo;

   modport master (
      output start, op, a_in, b_in,
      input  busy, done, div_by_zero, z_hi, z_lo
   );

   modport slave (
      input  start, op, a_in, b_in,
      output busy, done, div_by_zero, z_hi, z_lo
   );
endinterface

// File: rtl/mul_div_unit.sv
// Multi-cycle signed multiplier (radix-2 Booth) and divider (restoring, magnitude + sign fix).
// One iteration per RUN cycle, then a FIX cycle that registers the Z halves on entry to DONE.
module mul_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic          clock,
   input  logic          clear,
   mul_div_unit_if.slave bus
);
   localparam int CNT_W = $clog2(WIDTH);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

   state_t                   r_state;
   state_t                   w_next;
   logic [CNT_W-1:0]         r_cnt;
   logic                     r_dbz;
   logic [WIDTH-1:0]         r_z_hi;
   logic [WIDTH-1:0]         r_z_lo;

   logic                     r_op;
   logic                     r_a_neg;
   logic                     r_b_neg;
   logic signed [WIDTH:0]    r_acc;
   logic [WIDTH-1:0]         r_q;
   logic                     r_qm1;
   logic [WIDTH-1:0]         r_m;

   logic                     w_accept;
   logic                     w_dbz_start;
   logic                     w_last;
   logic signed [WIDTH:0]    w_mext;
   logic signed [WIDTH:0]    w_booth;
   logic [WIDTH:0]           w_rem_sh;
   logic [WIDTH:0]           w_diff;
   logic signed [WIDTH:0]    w_acc_next;
   logic [WIDTH-1:0]         w_q_next;
   logic                     w_qm1_next;
   logic [WIDTH-1:0]         w_res_hi;
   logic [WIDTH-1:0]         w_res_lo;

   function automatic logic [WIDTH-1:0] f_neg(input logic [WIDTH-1:0] v);
      return '0 - v;
   endfunction

   function automatic logic [WIDTH-1:0] f_abs(input logic [WIDTH-1:0] v);
      return v[WIDTH-1] ? f_neg(v) : v;
   endfunction

   assign w_accept    = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));
   assign w_dbz_start = w_accept && bus.op && (bus.b_in == '0);
   assign w_last      = (r_cnt == CNT_W'(WIDTH - 1));

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (w_accept) w_next = w_dbz_start ? S_DONE : S_RUN;
            else          w_next = S_IDLE;
         end
         S_RUN:   if (w_last) w_next = S_FIX;
         S_FIX:   w_next = S_DONE;
         default: w_next = S_IDLE;
      endcase
   end

   // Single iteration: Booth add/sub + arithmetic shift, or one restoring divide step.
   always_comb begin
      w_mext     = {r_m[WIDTH-1], r_m};
      w_booth    = r_acc;
      w_rem_sh   = {r_acc[WIDTH-1:0], r_q[WIDTH-1]};
      w_diff     = w_rem_sh - {1'b0, r_m};
      w_acc_next = r_acc;
      w_q_next   = r_q;
      w_qm1_next = r_qm1;
      if (!r_op) begin
         case ({r_q[0], r_qm1})
            2'b01:   w_booth = r_acc + w_mext;
            2'b10:   w_booth = r_acc - w_mext;
            default: w_booth = r_acc;
         endcase
         {w_acc_next, w_q_next, w_qm1_next} = {w_booth[WIDTH], w_booth, r_q};
      end else if (!w_diff[WIDTH]) begin
         w_acc_next = w_diff;
         w_q_next   = {r_q[WIDTH-2:0], 1'b1};
      end else begin
         w_acc_next = w_rem_sh;
         w_q_next   = {r_q[WIDTH-2:0], 1'b0};
      end
   end

   always_comb begin
      w_res_hi = r_acc[WIDTH-1:0];
      w_res_lo = r_q;
      if (r_op) begin
         w_res_lo = (r_a_neg ^ r_b_neg) ? f_neg(r_q) : r_q;
         w_res_hi = r_a_neg ? f_neg(r_acc[WIDTH-1:0]) : r_acc[WIDTH-1:0];
      end
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_dbz   <= 1'b0;
         r_z_hi  <= '0;
         r_z_lo  <= '0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_cnt <= '0;
            r_dbz <= w_dbz_start;
            if (w_dbz_start) begin
               r_z_hi <= bus.a_in;
               r_z_lo <= '1;
            end
         end else if (r_state == S_RUN) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
         if (r_state == S_FIX) begin
            r_z_hi <= w_res_hi;
            r_z_lo <= w_res_lo;
         end
      end
   end

   // Working registers carry no reset; they are reloaded on every accepted start.
   always_ff @(posedge clock) begin
      if (w_accept) begin
         r_op    <= bus.op;
         r_a_neg <= bus.a_in[WIDTH-1];
         r_b_neg <= bus.b_in[WIDTH-1];
         r_acc   <= '0;
         r_qm1   <= 1'b0;
         if (bus.op) begin
            r_q <= f_abs(bus.a_in);
            r_m <= f_abs(bus.b_in);
         end else begin
            r_q <= bus.b_in;
            r_m <= bus.a_in;
         end
      end else if (r_state == S_RUN) begin
         r_acc <= w_acc_next;
         r_q   <= w_q_next;
         r_qm1 <= w_qm1_next;
      end
   end

   assign bus.busy        = (r_state == S_RUN) || (r_state == S_FIX);
   assign bus.done        = (r_state == S_DONE);
   assign bus.div_by_zero = r_dbz;
   assign bus.z_hi        = r_z_hi;
   assign bus.z_lo        = r_z_lo;
endmodule
